// File: rtl/qdma_axis_pkg.sv
// Shared types and helpers for the QDMA <-> Coyote AXI4-Stream adapters.
//
// Contents:
//   LEGAL_DATA_BITS - stream widths the adapters support
//   beat_t          - one stream beat {data, keep, last, sop}, sized for the
//                     widest legal stream; narrower users leave the upper bits zero
//   frame_state_t   - packet framing states
//   mty_to_keep()   - QDMA mty/zero_byte to AXI byte-enable conversion
package qdma_axis_pkg;

    localparam int MAX_DATA_BITS = 512;
    localparam int MAX_BYTES     = MAX_DATA_BITS / 8;
    localparam int MAX_MTY_BITS  = $clog2(MAX_BYTES);

    localparam int LEGAL_DATA_BITS [4] = '{64, 128, 256, 512};

    typedef struct packed {
        logic [MAX_DATA_BITS-1:0] data;
        logic [MAX_BYTES-1:0]     keep;
        logic                     last;
        logic                     sop;
    } beat_t;

    typedef enum logic [0:0] {
        IDLE,
        IN_PKT
    } frame_state_t;

    // Byte i is kept when i <= bytes-1-mty. Shifting an all-ones mask right
    // by (MAX_BYTES-bytes)+mty leaves exactly bytes-mty low bits set, so the
    // subtraction never goes negative. Bits at and above 'bytes' stay zero.
    function automatic logic [MAX_BYTES-1:0] mty_to_keep(
        input logic [MAX_MTY_BITS-1:0] mty,
        input logic                    zero_byte,
        input int                      bytes
    );
        logic [MAX_BYTES-1:0] ones;
        logic [MAX_BYTES-1:0] keep;
        int                   shift;
        ones  = '1;
        shift = (MAX_BYTES - bytes) + int'(mty);
        keep  = ones >> shift;
        return keep & ~{MAX_BYTES{zero_byte}};
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register slice for beat_t streams.
//
// Output register plus one skid register. s_ready is registered and equals
// "skid register empty", so the upstream sees no combinational path from
// m_ready. Full throughput under backpressure; order is preserved.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   s_valid/s_ready - upstream handshake, s_beat upstream beat
//   m_valid/m_ready - downstream handshake, m_beat downstream beat (held
//                     stable while m_valid & !m_ready)
module axis_skid_buf
    import qdma_axis_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  s_valid,
    output logic  s_ready,
    input  beat_t s_beat,
    output logic  m_valid,
    input  logic  m_ready,
    output beat_t m_beat
);

    beat_t out_beat_p1;
    beat_t skid_beat_p1;
    logic  out_vld_p1;
    logic  skid_vld_p1;
    logic  rdy_p1;

    beat_t out_beat_n;
    beat_t skid_beat_n;
    logic  out_vld_n;
    logic  skid_vld_n;
    logic  s_fire;
    logic  out_load;

    assign s_fire   = s_valid & rdy_p1;
    assign out_load = ~out_vld_p1 | m_ready;

    always_comb begin
        out_beat_n  = out_beat_p1;
        skid_beat_n = skid_beat_p1;
        out_vld_n   = out_vld_p1;
        skid_vld_n  = skid_vld_p1;
        if (out_load) begin
            if (skid_vld_p1) begin
                // Oldest beat lives in the skid register: it goes out first.
                out_beat_n = skid_beat_p1;
                out_vld_n  = 1'b1;
                skid_vld_n = s_fire;
                if (s_fire) begin
                    skid_beat_n = s_beat;
                end
            end else begin
                out_vld_n = s_fire;
                if (s_fire) begin
                    out_beat_n = s_beat;
                end
            end
        end else if (s_fire) begin
            skid_beat_n = s_beat;
            skid_vld_n  = 1'b1;
        end
    end

    // ---- stage p1: output / skid registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_beat_p1  <= '0;
            skid_beat_p1 <= '0;
            out_vld_p1   <= 1'b0;
            skid_vld_p1  <= 1'b0;
            rdy_p1       <= 1'b0;
        end else begin
            out_beat_p1  <= out_beat_n;
            skid_beat_p1 <= skid_beat_n;
            out_vld_p1   <= out_vld_n;
            skid_vld_p1  <= skid_vld_n;
            rdy_p1       <= ~skid_vld_n;
        end
    end

    assign s_ready = rdy_p1;
    assign m_valid = out_vld_p1;
    assign m_beat  = out_beat_p1;

endmodule

// File: rtl/qdma_axis_tkeep_conv.sv
// QDMA streaming beat (data, mty, zero_byte, tlast) to Coyote AXI4-Stream
// beat (data, tkeep, tlast, tuser=SOP), registered through a 2-entry skid
// buffer. Tracks packet framing, flags mty on non-last beats, counts packets.
//
// Optional feature macro: QDMA_TKEEP_BYTECNT_EN adds per-packet byte totals
// (pkt_bytes, pkt_bytes_valid).
//
// Ports:
//   aclk, areset        - clock, asynchronous active-high reset
//   s_qdma_*            - QDMA input beat and handshake
//   m_axis_*            - AXI4-Stream output beat and handshake
//   err_mty             - sticky: nonzero mty seen on a non-last input beat
//   pkt_cnt             - packets completed on the output side (wraps)
//   pkt_bytes(_valid)   - packet byte total and its 1-cycle strobe (optional)
module qdma_axis_tkeep_conv
    import qdma_axis_pkg::*;
#(
    parameter  int DATA_BITS = 512,
    localparam int BYTES     = DATA_BITS / 8,
    localparam int MTY_BITS  = $clog2(BYTES)
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 s_qdma_tvalid,
    output logic                 s_qdma_tready,
    input  logic [DATA_BITS-1:0] s_qdma_tdata,
    input  logic [MTY_BITS-1:0]  s_qdma_mty,
    input  logic                 s_qdma_zero_byte,
    input  logic                 s_qdma_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic [BYTES-1:0]     m_axis_tkeep,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,
    output logic                 err_mty,
    output logic [31:0]          pkt_cnt
`ifdef QDMA_TKEEP_BYTECNT_EN
    ,
    output logic [31:0]          pkt_bytes,
    output logic                 pkt_bytes_valid
`endif
);

    if (DATA_BITS != LEGAL_DATA_BITS[0] && DATA_BITS != LEGAL_DATA_BITS[1] &&
        DATA_BITS != LEGAL_DATA_BITS[2] && DATA_BITS != LEGAL_DATA_BITS[3]) begin : g_bad_width
        $error("qdma_axis_tkeep_conv: DATA_BITS must be 64, 128, 256 or 512");
    end

    frame_state_t state;
    frame_state_t state_n;
    logic         sop;
    logic         s_fire;
    logic         m_fire;
    beat_t        in_beat;
    beat_t        out_beat;

    assign s_fire = s_qdma_tvalid & s_qdma_tready;
    assign m_fire = m_axis_tvalid & m_axis_tready;

    // Framing advances on the input handshake; SOP is the IDLE state.
    always_comb begin
        state_n = state;
        sop     = (state == IDLE);
        if (s_fire) begin
            state_n = s_qdma_tlast ? IDLE : IN_PKT;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        in_beat                      = '0;
        in_beat.data[DATA_BITS-1:0]  = s_qdma_tdata;
        in_beat.keep                 = mty_to_keep(MAX_MTY_BITS'(s_qdma_mty), s_qdma_zero_byte, BYTES);
        in_beat.last                 = s_qdma_tlast;
        in_beat.sop                  = sop;
    end

    // ---- stage p1: registered output through the skid buffer ----
    axis_skid_buf u_skid (
        .clk     (aclk),
        .rst     (areset),
        .s_valid (s_qdma_tvalid),
        .s_ready (s_qdma_tready),
        .s_beat  (in_beat),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready),
        .m_beat  (out_beat)
    );

    assign m_axis_tdata = out_beat.data[DATA_BITS-1:0];
    assign m_axis_tkeep = out_beat.keep[BYTES-1:0];
    assign m_axis_tlast = out_beat.last;
    assign m_axis_tuser = out_beat.sop;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            err_mty <= 1'b0;
            pkt_cnt <= '0;
        end else begin
            if (s_fire && !s_qdma_tlast && (s_qdma_mty != '0)) begin
                err_mty <= 1'b1;
            end
            if (m_fire && m_axis_tlast) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end

`ifdef QDMA_TKEEP_BYTECNT_EN
    logic [31:0] byte_acc;
    logic [31:0] beat_bytes;

    assign beat_bytes = 32'($countones(m_axis_tkeep));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            byte_acc        <= '0;
            pkt_bytes       <= '0;
            pkt_bytes_valid <= 1'b0;
        end else begin
            pkt_bytes_valid <= 1'b0;
            if (m_fire) begin
                if (m_axis_tlast) begin
                    pkt_bytes       <= byte_acc + beat_bytes;
                    pkt_bytes_valid <= 1'b1;
                    byte_acc        <= '0;
                end else begin
                    byte_acc <= byte_acc + beat_bytes;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_qdma_axis_tkeep_conv.sv
// Bench for qdma_axis_tkeep_conv (DATA_BITS=512): directed packets plus a
// randomized backpressured stream, checked against a queue-based model.
module tb_qdma_axis_tkeep_conv;

    localparam int DW = 512;
    localparam int NB = 64;
    localparam int MB = 6;

    logic          aclk = 1'b0;
    logic          areset;
    logic          s_qdma_tvalid;
    logic          s_qdma_tready;
    logic [DW-1:0] s_qdma_tdata;
    logic [MB-1:0] s_qdma_mty;
    logic          s_qdma_zero_byte;
    logic          s_qdma_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [NB-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          err_mty;
    logic [31:0]   pkt_cnt;
`ifdef QDMA_TKEEP_BYTECNT_EN
    logic [31:0]   pkt_bytes;
    logic          pkt_bytes_valid;
`endif

    always #5 aclk = ~aclk;

    qdma_axis_tkeep_conv #(.DATA_BITS(DW)) dut (
        .aclk             (aclk),
        .areset           (areset),
        .s_qdma_tvalid    (s_qdma_tvalid),
        .s_qdma_tready    (s_qdma_tready),
        .s_qdma_tdata     (s_qdma_tdata),
        .s_qdma_mty       (s_qdma_mty),
        .s_qdma_zero_byte (s_qdma_zero_byte),
        .s_qdma_tlast     (s_qdma_tlast),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .err_mty          (err_mty),
        .pkt_cnt          (pkt_cnt)
`ifdef QDMA_TKEEP_BYTECNT_EN
        ,
        .pkt_bytes        (pkt_bytes),
        .pkt_bytes_valid  (pkt_bytes_valid)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic [NB-1:0] keep;
        logic          last;
        logic          sop;
    } exp_t;

    exp_t        q[$];
    bit          in_pkt;
    bit          err_m;
    logic [31:0] cnt_m;
    bit          rdy_m;
    logic [31:0] acc_m;
    logic [31:0] pbytes_m;
    bit          pbv_m;

    bit            stall;
    logic [DW-1:0] h_data;
    logic [NB-1:0] h_keep;
    logic          h_last;
    logic          h_user;

    logic [NB-1:0] obs_keep;
    logic          obs_last;
    logic          obs_user;
    bit            obs_fire;
    bit            took;

    // Bytes 0 .. NB-1-mty carry data unless the beat is a zero-byte beat.
    function automatic logic [NB-1:0] ref_keep(input int mty, input bit zb);
        logic [NB-1:0] k;
        k = '0;
        if (!zb) begin
            for (int b = 0; b < NB - mty; b++) k[b] = 1'b1;
        end
        return k;
    endfunction

    function automatic logic [DW-1:0] rnd512();
        logic [DW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_clear();
        q.delete();
        in_pkt   = 1'b0;
        err_m    = 1'b0;
        cnt_m    = '0;
        rdy_m    = 1'b0;
        acc_m    = '0;
        pbytes_m = '0;
        pbv_m    = 1'b0;
        stall    = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_tvalid"}, 512'(m_axis_tvalid), 512'(0));
        chk({tag, "_tdata"},  512'(m_axis_tdata),  512'(0));
        chk({tag, "_tkeep"},  512'(m_axis_tkeep),  512'(0));
        chk({tag, "_tlast"},  512'(m_axis_tlast),  512'(0));
        chk({tag, "_tuser"},  512'(m_axis_tuser),  512'(0));
        chk({tag, "_err"},    512'(err_mty),       512'(0));
        chk({tag, "_pktcnt"}, 512'(pkt_cnt),       512'(0));
        chk({tag, "_tready"}, 512'(s_qdma_tready), 512'(0));
`ifdef QDMA_TKEEP_BYTECNT_EN
        chk({tag, "_pbytes"}, 512'(pkt_bytes),       512'(0));
        chk({tag, "_pbv"},    512'(pkt_bytes_valid), 512'(0));
`endif
    endtask

    // One clock: check registered state at the falling edge, drive the
    // inputs for the next rising edge and advance the model across it.
    task automatic step(input bit v, input logic [DW-1:0] d, input int mty,
                        input bit zb, input bit last, input bit mrdy, output bit accepted);
        bit   in_fire;
        bit   out_fire;
        exp_t e;
        @(negedge aclk);
        chk("tready",  512'(s_qdma_tready), 512'(rdy_m));
        chk("tvalid",  512'(m_axis_tvalid), 512'(q.size() > 0));
        chk("err_mty", 512'(err_mty),       512'(err_m));
        chk("pkt_cnt", 512'(pkt_cnt),       512'(cnt_m));
`ifdef QDMA_TKEEP_BYTECNT_EN
        chk("pbv", 512'(pkt_bytes_valid), 512'(pbv_m));
        if (pbv_m) chk("pkt_bytes", 512'(pkt_bytes), 512'(pbytes_m));
`endif
        if (stall) begin
            chk("hold_data", 512'(m_axis_tdata), 512'(h_data));
            chk("hold_keep", 512'(m_axis_tkeep), 512'(h_keep));
            chk("hold_last", 512'(m_axis_tlast), 512'(h_last));
            chk("hold_user", 512'(m_axis_tuser), 512'(h_user));
        end

        s_qdma_tvalid    = v;
        s_qdma_tdata     = d;
        s_qdma_mty       = MB'(mty);
        s_qdma_zero_byte = zb;
        s_qdma_tlast     = last;
        m_axis_tready    = mrdy;

        in_fire  = v && s_qdma_tready;
        out_fire = m_axis_tvalid && mrdy;
        obs_fire = out_fire;
        accepted = in_fire;
        pbv_m    = 1'b0;

        if (out_fire) begin
            obs_keep = m_axis_tkeep;
            obs_last = m_axis_tlast;
            obs_user = m_axis_tuser;
            if (q.size() == 0) begin
                chk("underflow", 512'(1), 512'(0));
            end else begin
                e = q.pop_front();
                chk("out_data", 512'(m_axis_tdata), 512'(e.data));
                chk("out_keep", 512'(m_axis_tkeep), 512'(e.keep));
                chk("out_last", 512'(m_axis_tlast), 512'(e.last));
                chk("out_user", 512'(m_axis_tuser), 512'(e.sop));
                acc_m = acc_m + 32'($countones(e.keep));
                if (e.last) begin
                    cnt_m    = cnt_m + 32'd1;
                    pbytes_m = acc_m;
                    pbv_m    = 1'b1;
                    acc_m    = '0;
                end
            end
        end

        stall  = m_axis_tvalid && !mrdy;
        h_data = m_axis_tdata;
        h_keep = m_axis_tkeep;
        h_last = m_axis_tlast;
        h_user = m_axis_tuser;

        if (in_fire) begin
            e.data = d;
            e.keep = ref_keep(mty, zb);
            e.last = last;
            e.sop  = !in_pkt;
            in_pkt = !last;
            if (!last && mty != 0) err_m = 1'b1;
            q.push_back(e);
        end
        rdy_m = !areset && (q.size() < 2);
    endtask

    task automatic idle(input bit mrdy);
        step(1'b0, '0, 0, 1'b0, 1'b0, mrdy, took);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        int guard;
        bit have;
        bit v;
        bit zb;
        bit last;
        int mty;
        logic [DW-1:0] d;

        areset           = 1'b0;
        s_qdma_tvalid    = 1'b0;
        s_qdma_tdata     = '0;
        s_qdma_mty       = '0;
        s_qdma_zero_byte = 1'b0;
        s_qdma_tlast     = 1'b0;
        m_axis_tready    = 1'b0;
        model_clear();

        #1 areset = 1'b1;
        #1 chk_reset("por");
        idle(1'b0);
        idle(1'b0);
        areset = 1'b0;
        rdy_m  = 1'b1;

        // 3-beat packet, mty 0,0,5, tready held high
        step(1'b1, rnd512(), 0, 1'b0, 1'b0, 1'b1, took);
        step(1'b1, rnd512(), 0, 1'b0, 1'b0, 1'b1, took);
        chk("p3_b1_user", 512'(obs_user), 512'(1));
        chk("p3_b1_keep", 512'(obs_keep), 512'({NB{1'b1}}));
        step(1'b1, rnd512(), 5, 1'b0, 1'b1, 1'b1, took);
        chk("p3_b2_user", 512'(obs_user), 512'(0));
        idle(1'b1);
        chk("p3_b3_keep", 512'(obs_keep), 512'(64'h07FF_FFFF_FFFF_FFFF));
        chk("p3_b3_last", 512'(obs_last), 512'(1));
        chk("p3_b3_user", 512'(obs_user), 512'(0));
        idle(1'b1);
        chk("p3_pkt_cnt", 512'(pkt_cnt), 512'(1));

        // single-beat packets at the mty boundary
        step(1'b1, rnd512(), 63, 1'b0, 1'b1, 1'b1, took);
        idle(1'b1);
        chk("mty63_keep", 512'(obs_keep), 512'(1));
        chk("mty63_user", 512'(obs_user), 512'(1));
        chk("mty63_last", 512'(obs_last), 512'(1));
        step(1'b1, rnd512(), 63, 1'b1, 1'b1, 1'b1, took);
        idle(1'b1);
        chk("zb_keep", 512'(obs_keep), 512'(0));
        chk("zb_user", 512'(obs_user), 512'(1));
        chk("zb_last", 512'(obs_last), 512'(1));

        // 100-beat stream with random gaps and random backpressure
        sent  = 0;
        guard = 0;
        have  = 1'b0;
        d     = '0;
        mty   = 0;
        zb    = 1'b0;
        last  = 1'b0;
        while (sent < 100 && guard < 3000) begin
            if (!have) begin
                d    = rnd512();
                last = ($urandom % 4) == 0;
                mty  = last ? int'($urandom % 64) : 0;
                zb   = ($urandom % 16) == 0;
                have = 1'b1;
            end
            v = ($urandom % 4) != 0;
            step(v, d, mty, zb, last, 1'($urandom % 2), took);
            if (took) begin
                have = 1'b0;
                sent++;
            end
            guard++;
        end
        chk("stream_sent", 512'(sent), 512'(100));
        // close any open packet, then drain
        step(1'b1, rnd512(), 0, 1'b0, 1'b1, 1'b1, took);
        while (!took && guard < 3100) begin
            step(1'b1, rnd512(), 0, 1'b0, 1'b1, 1'b1, took);
            guard++;
        end
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("drain_empty", 512'(q.size()), 512'(0));
        chk("err_clean", 512'(err_mty), 512'(0));

        // mty on a non-last beat: sticky error, beat still forwarded
        step(1'b1, rnd512(), 3, 1'b0, 1'b0, 1'b1, took);
        idle(1'b1);
        chk("err_rise", 512'(err_mty), 512'(1));
        chk("err_beat_keep", 512'(obs_keep), 512'({3'b000, {(NB-3){1'b1}}}));
        step(1'b1, rnd512(), 0, 1'b0, 1'b1, 1'b1, took);
        step(1'b1, rnd512(), 0, 1'b0, 1'b0, 1'b1, took);
        step(1'b1, rnd512(), 7, 1'b0, 1'b1, 1'b1, took);
        for (int i = 0; i < 3; i++) idle(1'b1);
        chk("err_sticky", 512'(err_mty), 512'(1));

        // reset in the middle of a 4-beat packet with beats in flight
        step(1'b1, rnd512(), 0, 1'b0, 1'b0, 1'b0, took);
        step(1'b1, rnd512(), 0, 1'b0, 1'b0, 1'b0, took);
        #2 areset = 1'b1;
        #1 chk_reset("mid");
        s_qdma_tvalid = 1'b0;
        model_clear();
        idle(1'b1);
        idle(1'b1);
        areset = 1'b0;
        rdy_m  = 1'b1;
        step(1'b1, rnd512(), 0, 1'b0, 1'b1, 1'b1, took);
        idle(1'b1);
        chk("post_rst_sop", 512'(obs_user), 512'(1));
        chk("post_rst_fire", 512'(obs_fire), 512'(1));

        // 2-beat packet, mty 0 then 3
        step(1'b1, rnd512(), 0, 1'b0, 1'b0, 1'b1, took);
        step(1'b1, rnd512(), 3, 1'b0, 1'b1, 1'b1, took);
        idle(1'b1);
        idle(1'b1);
`ifdef QDMA_TKEEP_BYTECNT_EN
        chk("bytes_total", 512'(pkt_bytes), 512'(125));
        chk("bytes_pulse", 512'(pkt_bytes_valid), 512'(1));
`endif
        idle(1'b1);
        idle(1'b1);
        chk("final_pkt_cnt", 512'(pkt_cnt), 512'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
